// File: rtl/spmv_pkg.sv
// Shared types and constants for the SpMV kernel row-pointer front end.
package spmv_pkg;

  localparam int PTR_W_DEF = 32;
  localparam int LEN_W_DEF = 32;

  // Wide all-ones source; users slice it to their own length width.
  localparam logic [63:0] LEN_SAT = '1;

  typedef enum logic {
    BASE = 1'b0,
    RUN  = 1'b1
  } row_len_state_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream register slice: registered ready (= not full), registered output.
module axis_skid_buf #(
  parameter int DW = 33
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  output logic          in_ready_o,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  input  logic          out_ready_i
);

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          skid_valid_q, skid_valid_d;
  logic [DW-1:0] skid_data_q, skid_data_d;
  logic          in_ready_q;
  logic          push, pop;

  assign push = in_valid_i && in_ready_q;
  assign pop  = out_valid_q && out_ready_i;

  always_comb begin
    // NOTE: every _d starts from its current value so no branch leaves it unassigned (no latch).
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (skid_valid_q) begin
      // Full: input is blocked, the skid entry refills the output slot on a pop.
      if (pop) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (!out_valid_q || pop) begin
      out_valid_d = push;
      if (push) out_data_d = in_data_i;
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      // NOTE: payload registers are reset too, because the output data has a defined reset value.
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/row_len_gen.sv
// CSR row-pointer stream to per-row nonzero-count stream.
// Optional row/nnz statistics counters enabled by defining ROW_LEN_GEN_STATS_EN.
module row_len_gen
  import spmv_pkg::*;
#(
  parameter int PTR_W = PTR_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ptr_valid,
  input  logic [PTR_W-1:0] ptr_data,
  input  logic             ptr_last,
  output logic             ptr_ready,
  output logic             times_valid,
  output logic [LEN_W-1:0] times_data,
  output logic             times_last,
  input  logic             times_ready,
  output logic             mat_done,
  output logic             ptr_err,
  output logic [31:0]      row_cnt,
  output logic [47:0]      nnz_cnt
);

  row_len_state_t   state_q;
  logic [PTR_W-1:0] prev_q;
  logic             ptr_err_q;
  logic             mat_done_q;

  logic             accept;
  logic             out_hs;
  logic [PTR_W-1:0] diff;
  logic             under;
  logic             over;
  logic [LEN_W-1:0] len;

  assign accept = ptr_valid && ptr_ready;
  assign out_hs = times_valid && times_ready;
  assign diff   = ptr_data - prev_q;
  assign under  = ptr_data < prev_q;

  generate
    if (LEN_W < PTR_W) begin : g_ovf
      assign over = |diff[PTR_W-1:LEN_W];
    end else begin : g_no_ovf
      assign over = 1'b0;
    end
  endgenerate

  always_comb begin
    len = diff[LEN_W-1:0];
    if (under)     len = '0;
    else if (over) len = LEN_SAT[LEN_W-1:0];
  end

  // Only pointers after row_ptr[0] produce a length; the buffer supplies ptr_ready.
  axis_skid_buf #(
    .DW (LEN_W + 1)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (ptr_valid && (state_q == RUN)),
    .in_data_i   ({ptr_last, len}),
    .in_ready_o  (ptr_ready),
    .out_valid_o (times_valid),
    .out_data_o  ({times_last, times_data}),
    .out_ready_i (times_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BASE;
      prev_q     <= '0;
      ptr_err_q  <= 1'b0;
      mat_done_q <= 1'b0;
    end else begin
      mat_done_q <= (out_hs && times_last) || (accept && (state_q == BASE) && ptr_last);
      if (accept) begin
        prev_q <= ptr_data;
        case (state_q)
          BASE: if (!ptr_last) state_q <= RUN;
          RUN: begin
            if (under || over) ptr_err_q <= 1'b1;
            if (ptr_last) state_q <= BASE;
          end
          default: state_q <= BASE;
        endcase
      end
    end
  end

  assign mat_done = mat_done_q;
  assign ptr_err  = ptr_err_q;

`ifdef ROW_LEN_GEN_STATS_EN
  logic [31:0] row_cnt_q, row_cnt_d;
  logic [47:0] nnz_cnt_q, nnz_cnt_d;

  // A handshake in the clearing cycle belongs to the next matrix, so it is kept.
  always_comb begin
    row_cnt_d = mat_done_q ? '0 : row_cnt_q;
    nnz_cnt_d = mat_done_q ? '0 : nnz_cnt_q;
    if (out_hs) begin
      row_cnt_d = row_cnt_d + 32'd1;
      nnz_cnt_d = nnz_cnt_d + 48'(times_data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt_q <= '0;
      nnz_cnt_q <= '0;
    end else begin
      row_cnt_q <= row_cnt_d;
      nnz_cnt_q <= nnz_cnt_d;
    end
  end

  assign row_cnt = row_cnt_q;
  assign nnz_cnt = nnz_cnt_q;
`else
  assign row_cnt = '0;
  assign nnz_cnt = '0;
`endif

endmodule

// File: tb/tb_row_len_gen.sv
// Randomized self-checking bench for row_len_gen against a queue-based row-length model.
module tb_row_len_gen;

`ifdef ROW_LEN_GEN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ptr_valid = 1'b0;
  logic [31:0] ptr_data  = '0;
  logic        ptr_last  = 1'b0;
  logic        ptr_ready;
  logic        times_valid;
  logic [31:0] times_data;
  logic        times_last;
  logic        times_ready = 1'b0;
  logic        mat_done, ptr_err;
  logic [31:0] row_cnt;
  logic [47:0] nnz_cnt;

  row_len_gen dut (
    .clk(clk), .rst(rst),
    .ptr_valid(ptr_valid), .ptr_data(ptr_data), .ptr_last(ptr_last), .ptr_ready(ptr_ready),
    .times_valid(times_valid), .times_data(times_data), .times_last(times_last),
    .times_ready(times_ready), .mat_done(mat_done), .ptr_err(ptr_err),
    .row_cnt(row_cnt), .nnz_cnt(nnz_cnt)
  );

  logic        p8_valid = 1'b0;
  logic [31:0] p8_data  = '0;
  logic        p8_last  = 1'b0;
  logic        p8_ready;
  logic        t8_valid;
  logic [7:0]  t8_data;
  logic        t8_last;
  logic        t8_ready = 1'b1;
  logic        d8_done, d8_err;
  logic [31:0] d8_rows;
  logic [47:0] d8_nnz;

  row_len_gen #(.PTR_W(32), .LEN_W(8)) dut8 (
    .clk(clk), .rst(rst),
    .ptr_valid(p8_valid), .ptr_data(p8_data), .ptr_last(p8_last), .ptr_ready(p8_ready),
    .times_valid(t8_valid), .times_data(t8_data), .times_last(t8_last),
    .times_ready(t8_ready), .mat_done(d8_done), .ptr_err(d8_err),
    .row_cnt(d8_rows), .nnz_cnt(d8_nnz)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask

  typedef struct packed { logic [31:0] len; logic last; } exp_t;
  typedef struct packed { logic [31:0] d;   logic l;    } src_t;

  exp_t        exp_q[$];
  src_t        src_q[$];
  logic [31:0] out_log[$];

  // Reference state: the matrix-level view of the stream.
  bit          m_base = 1'b1;
  logic [31:0] m_prev = '0;
  bit          m_err  = 1'b0;
  bit          m_done = 1'b0;
  logic [31:0] m_rows = '0;
  logic [47:0] m_nnz  = '0;

  int          mode   = 0;   // 0 ready, 1 toggle, 2 random, 3 stalled
  int          bubble = 0;
  bit          tog    = 1'b1;
  int          done_seen = 0;
  logic [31:0] done_rows = '0;
  logic [47:0] done_nnz  = '0;

  task automatic add(input logic [31:0] d, input logic l);
    src_t s;
    s.d = d;
    s.l = l;
    src_q.push_back(s);
  endtask

  // One cycle: check outputs, drive inputs, advance the model, cross the edge.
  task automatic tick();
    logic acc, ohs, nd;
    exp_t e;
    src_t s;
    check("mat_done", 64'(mat_done), 64'(m_done));
    check("ptr_err", 64'(ptr_err), 64'(m_err));
    check("ptr_ready", 64'(ptr_ready), 64'(exp_q.size() < 2));
    check("times_valid", 64'(times_valid), 64'(exp_q.size() != 0));
    if (times_valid && exp_q.size() != 0) begin
      check("times_data", 64'(times_data), 64'(exp_q[0].len));
      check("times_last", 64'(times_last), 64'(exp_q[0].last));
    end
    check("row_cnt", 64'(row_cnt), STATS ? 64'(m_rows) : 64'd0);
    check("nnz_cnt", 64'(nnz_cnt), STATS ? 64'(m_nnz) : 64'd0);
    if (mat_done) begin
      done_seen++;
      done_rows = row_cnt;
      done_nnz  = nnz_cnt;
    end

    case (mode)
      0:       times_ready = 1'b1;
      1:       begin times_ready = tog; tog = !tog; end
      2:       times_ready = 1'($urandom_range(1));
      default: times_ready = 1'b0;
    endcase
    ptr_valid = (src_q.size() != 0) && ($urandom_range(99) >= 32'(bubble));
    if (src_q.size() != 0) begin
      ptr_data = src_q[0].d;
      ptr_last = src_q[0].l;
    end else begin
      ptr_data = 32'($urandom);
      ptr_last = 1'($urandom_range(1));
    end

    acc = ptr_valid && ptr_ready;
    ohs = times_valid && times_ready;
    nd  = 1'b0;
    if (m_done) begin
      m_rows = '0;
      m_nnz  = '0;
    end
    if (ohs && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      out_log.push_back(e.len);
      m_rows = m_rows + 1;
      m_nnz  = m_nnz + 48'(e.len);
      nd     = e.last;
    end
    if (acc) begin
      s = src_q.pop_front();
      if (m_base) begin
        m_prev = s.d;
        if (s.l) nd = 1'b1;
        else     m_base = 1'b0;
      end else begin
        if (s.d < m_prev) begin
          e.len = '0;
          m_err = 1'b1;
        end else begin
          e.len = s.d - m_prev;
        end
        e.last = s.l;
        exp_q.push_back(e);
        m_prev = s.d;
        if (s.l) m_base = 1'b1;
      end
    end
    m_done = nd;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int limit);
    int n = 0;
    while (src_q.size() != 0 || exp_q.size() != 0 || m_done) begin
      tick();
      n++;
      if (n > limit) begin
        check("timeout", 64'(n), 64'(limit));
        break;
      end
    end
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ptr_valid = 1'b0;
    ptr_last = 1'b0;
    times_ready = 1'b0;
    @(posedge clk);
    #1;
    check("rst_ptr_ready", 64'(ptr_ready), 64'd0);
    check("rst_times_valid", 64'(times_valid), 64'd0);
    check("rst_times_data", 64'(times_data), 64'd0);
    check("rst_times_last", 64'(times_last), 64'd0);
    check("rst_mat_done", 64'(mat_done), 64'd0);
    check("rst_ptr_err", 64'(ptr_err), 64'd0);
    check("rst_row_cnt", 64'(row_cnt), 64'd0);
    check("rst_nnz_cnt", 64'(nnz_cnt), 64'd0);
    exp_q.delete();
    src_q.delete();
    m_base = 1'b1;
    m_prev = '0;
    m_err  = 1'b0;
    m_done = 1'b0;
    m_rows = '0;
    m_nnz  = '0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ptr_ready_after_rst", 64'(ptr_ready), 64'd1);
  endtask

  task automatic check_log(input string tag, input logic [31:0] want[$]);
    check({tag, "_count"}, 64'(out_log.size()), 64'(want.size()));
    for (int i = 0; i < want.size(); i++)
      if (i < out_log.size()) check({tag, "_len"}, 64'(out_log[i]), 64'(want[i]));
  endtask

  task automatic send8(input logic [31:0] d, input logic l);
    int n = 0;
    p8_valid = 1'b1;
    p8_data  = d;
    p8_last  = l;
    while (!p8_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("p8_ready", 64'(p8_ready), 64'd1);
    @(posedge clk);
    #1;
    p8_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] w[$];
    logic [31:0] p;
    int rows;

    do_reset();

    // Basic matrix at full throughput.
    mode = 0; bubble = 0; out_log.delete(); done_seen = 0;
    add(0, 0); add(3, 0); add(3, 0); add(7, 0); add(12, 1);
    run(100);
    w = '{32'd3, 32'd0, 32'd4, 32'd5};
    check_log("t1", w);
    check("t1_done_pulses", 64'(done_seen), 64'd1);
    check("t1_rows_at_done", 64'(done_rows), STATS ? 64'd4 : 64'd0);
    check("t1_nnz_at_done", 64'(done_nnz), STATS ? 64'd12 : 64'd0);
    check("t1_err", 64'(ptr_err), 64'd0);

    // Same stream with a toggling consumer.
    mode = 1; tog = 1'b1; out_log.delete(); done_seen = 0;
    add(0, 0); add(3, 0); add(3, 0); add(7, 0); add(12, 1);
    run(100);
    check_log("t2", w);
    check("t2_done_pulses", 64'(done_seen), 64'd1);

    // Zero-row matrix followed by a one-row matrix.
    mode = 0; out_log.delete(); done_seen = 0;
    add(5, 1); add(5, 0); add(9, 1);
    run(100);
    w = '{32'd4};
    check_log("t3", w);
    check("t3_done_pulses", 64'(done_seen), 64'd2);

    // Decreasing pointer: zero length, sticky error.
    out_log.delete();
    add(10, 0); add(4, 1);
    run(100);
    add(20, 0); add(25, 1);
    run(100);
    w = '{32'd0, 32'd5};
    check_log("t4", w);
    check("t4_err_sticky", 64'(ptr_err), 64'd1);
    do_reset();

    // Fill the buffer while stalled, then reset mid-matrix.
    mode = 3;
    add(0, 0); add(2, 0); add(5, 0); add(9, 0);
    repeat (6) tick();
    check("t5_stalled_valid", 64'(times_valid), 64'd1);
    check("t5_full_ready", 64'(ptr_ready), 64'd0);
    do_reset();
    mode = 0; out_log.delete();
    add(1, 0); add(4, 1);
    run(100);
    w = '{32'd3};
    check_log("t5", w);

    // Random matrices, random bubbles and backpressure.
    mode = 2;
    for (int m = 0; m < 150; m++) begin
      rows = $urandom_range(0, 6);
      p = 32'($urandom_range(0, 1000));
      add(p, rows == 0);
      for (int r = 0; r < rows; r++) begin
        if (p > 0 && $urandom_range(19) == 0) p = 32'($urandom_range(0, p - 1));
        else p = p + 32'($urandom_range(0, 9));
        add(p, r == rows - 1);
      end
      bubble = (m % 3 == 0) ? 0 : 30;
    end
    run(20000);

    // Narrow length: saturation boundary.
    send8(0, 0); send8(255, 1);
    check("n8_valid", 64'(t8_valid), 64'd1);
    check("n8_max_len", 64'(t8_data), 64'd255);
    check("n8_last", 64'(t8_last), 64'd1);
    check("n8_no_err", 64'(d8_err), 64'd0);
    send8(0, 0); send8(256, 1);
    check("n8_sat_256", 64'(t8_data), 64'd255);
    check("n8_err", 64'(d8_err), 64'd1);
    send8(0, 0); send8(300, 1);
    check("n8_sat_300", 64'(t8_data), 64'd255);
    @(posedge clk);
    #1;
    check("n8_done", 64'(d8_done), 64'd1);
    check("n8_rows_at_done", 64'(d8_rows), STATS ? 64'd1 : 64'd0);
    check("n8_nnz_at_done", 64'(d8_nnz), STATS ? 64'd255 : 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("n8_idle_valid", 64'(t8_valid), 64'd0);
    check("n8_idle_done", 64'(d8_done), 64'd0);
    check("n8_rows_cleared", 64'(d8_rows), 64'd0);
    check("n8_nnz_cleared", 64'(d8_nnz), 64'd0);
    check("n8_err_held", 64'(d8_err), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
